// File: rtl/pcs_rx_link_ctrl.sv
// pcs_rx_link_ctrl: PCS receive link bring-up sequencer.
// Walks SerDes lock -> block sync -> AM lock -> deskew -> link up.
// Every wait stage has a timeout, and a failed stage restarts acquisition
// through a datapath reset pulse. In 10G mode there is a single lane and the
// AM and deskew stages are skipped.
//
// Optional build macro: PCS_RX_LINK_CTRL_LOSS_FILTER_EN
//   defined   : lock loss in LINK_UP has to last LOSS_FILTER consecutive cycles
//               before a restart. SerDes lock loss still restarts at once.
//   undefined : any single cycle of lock loss in LINK_UP restarts.
//
// Handshake note: this block has no valid/ready interfaces. All lock inputs
// are level-sensitive, and every output is a registered level.
module pcs_rx_link_ctrl #(
  parameter int IS_10G         = 0,
  parameter int LANE_N         = IS_10G ? 1 : 4,
  parameter int RST_CYC        = 8,
  parameter int BS_TIMEOUT     = 4096,
  parameter int AM_TIMEOUT     = 65536,
  parameter int DESKEW_TIMEOUT = 65536,
  parameter int LOSS_FILTER    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [LANE_N-1:0] serdes_lock_v_i,
  input  logic [LANE_N-1:0] bs_lock_v_i,
  input  logic [LANE_N-1:0] am_lock_v_i,
  input  logic              deskew_lock_v_i,
  output logic              dp_reset_o,
  output logic              link_up_o,
  output logic [2:0]        state_o,
  output logic [7:0]        retry_cnt_o,
  output logic [LANE_N-1:0] lane_fault_o
);

  localparam logic [2:0] RESET_DP    = 3'd0;
  localparam logic [2:0] WAIT_SERDES = 3'd1;
  localparam logic [2:0] WAIT_BS     = 3'd2;
  localparam logic [2:0] WAIT_AM     = 3'd3;
  localparam logic [2:0] WAIT_DESKEW = 3'd4;
  localparam logic [2:0] LINK_UP     = 3'd5;

  // The one shared timer must hold the largest count in use, including the
  // RESET_DP hold time.
  localparam int MAX_A = (BS_TIMEOUT > RST_CYC) ? BS_TIMEOUT : RST_CYC;
  localparam int MAX_B = (AM_TIMEOUT > DESKEW_TIMEOUT) ? AM_TIMEOUT : DESKEW_TIMEOUT;
  localparam int MAX_T = (IS_10G != 0) ? MAX_A : ((MAX_A > MAX_B) ? MAX_A : MAX_B);
  localparam int TW    = (MAX_T <= 2) ? 1 : $clog2(MAX_T);

  localparam logic [TW-1:0] RST_LAST = TW'(RST_CYC - 1);
  localparam logic [TW-1:0] BS_LAST  = TW'(BS_TIMEOUT - 1);
  localparam logic [TW-1:0] AM_LAST  = TW'(AM_TIMEOUT - 1);
  localparam logic [TW-1:0] DSK_LAST = TW'(DESKEW_TIMEOUT - 1);

`ifdef PCS_RX_LINK_CTRL_LOSS_FILTER_EN
  localparam int LOSS_LIMIT = LOSS_FILTER;
`else
  // A limit of one turns the loss counter into an immediate restart.
  // LOSS_FILTER has no effect in this build.
  localparam int LOSS_LIMIT = 1 + 0 * LOSS_FILTER;
`endif
  localparam int            LW        = (LOSS_LIMIT <= 2) ? 1 : $clog2(LOSS_LIMIT);
  localparam logic [LW-1:0] LOSS_LAST = LW'(LOSS_LIMIT - 1);

  logic [2:0]        r_state;
  logic [TW-1:0]     r_timer;
  logic              r_dp_reset;
  logic              r_link_up;
  logic [7:0]        r_retry;
  logic [LANE_N-1:0] r_lane_fault;
  logic [LW-1:0]     r_loss;

  logic [2:0]        w_state_nxt;
  logic              w_restart;
  logic [LANE_N-1:0] w_fault_nxt;
  logic [LW-1:0]     w_loss_nxt;
  logic              w_serdes_ok;
  logic              w_bs_ok;
  logic              w_am_ok;
  logic              w_dsk_ok;
  logic              w_all_ok;

  // In 10G mode the AM and deskew locks count as always present.
  assign w_serdes_ok = &serdes_lock_v_i;
  assign w_bs_ok     = &bs_lock_v_i;
  assign w_am_ok     = (IS_10G != 0) || (&am_lock_v_i);
  assign w_dsk_ok    = (IS_10G != 0) || deskew_lock_v_i;
  assign w_all_ok    = w_serdes_ok && w_bs_ok && w_am_ok && w_dsk_ok;

  // Next-state decode. A lock from an earlier stage is checked first, then
  // the stage lock, and the timeout last. A lock that arrives on the
  // timeout cycle therefore advances the stage.
  always_comb begin
    w_state_nxt = r_state;
    w_restart   = 1'b0;
    w_fault_nxt = r_lane_fault;
    w_loss_nxt  = '0;
    case (r_state)
      RESET_DP: begin
        if (r_timer == RST_LAST) w_state_nxt = WAIT_SERDES;
      end
      WAIT_SERDES: begin
        if (w_serdes_ok) w_state_nxt = WAIT_BS;
      end
      WAIT_BS: begin
        if (!w_serdes_ok) begin
          w_restart = 1'b1;
        end else if (w_bs_ok) begin
          w_state_nxt = (IS_10G != 0) ? LINK_UP : WAIT_AM;
        end else if (r_timer == BS_LAST) begin
          w_restart   = 1'b1;
          w_fault_nxt = ~bs_lock_v_i;
        end
      end
      WAIT_AM: begin
        if (!w_serdes_ok || !w_bs_ok) begin
          w_restart = 1'b1;
        end else if (w_am_ok) begin
          w_state_nxt = WAIT_DESKEW;
        end else if (r_timer == AM_LAST) begin
          w_restart   = 1'b1;
          w_fault_nxt = ~am_lock_v_i;
        end
      end
      WAIT_DESKEW: begin
        if (!w_serdes_ok || !w_bs_ok || !w_am_ok) begin
          w_restart = 1'b1;
        end else if (w_dsk_ok) begin
          w_state_nxt = LINK_UP;
        end else if (r_timer == DSK_LAST) begin
          w_restart   = 1'b1;
          w_fault_nxt = '1;
        end
      end
      LINK_UP: begin
        if (!w_serdes_ok) begin
          w_restart = 1'b1;
        end else if (!w_all_ok) begin
          if (r_loss == LOSS_LAST) w_restart = 1'b1;
          else                     w_loss_nxt = r_loss + 1'b1;
        end
      end
      default: w_state_nxt = RESET_DP;
    endcase
    if (w_restart) w_state_nxt = RESET_DP;
  end

  // State, timer, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= RESET_DP;
      r_timer      <= '0;
      r_dp_reset   <= 1'b1;
      r_link_up    <= 1'b0;
      r_retry      <= 8'd0;
      r_lane_fault <= '0;
      r_loss       <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_timer      <= (w_state_nxt != r_state) ? '0 : r_timer + 1'b1;
      r_dp_reset   <= (w_state_nxt == RESET_DP);
      r_link_up    <= (w_state_nxt == LINK_UP);
      r_lane_fault <= w_fault_nxt;
      r_loss       <= w_loss_nxt;
      if (w_restart && (r_retry != 8'hFF)) r_retry <= r_retry + 8'd1;
    end
  end

  assign dp_reset_o   = r_dp_reset;
  assign link_up_o    = r_link_up;
  assign state_o      = r_state;
  assign retry_cnt_o  = r_retry;
  assign lane_fault_o = r_lane_fault;

endmodule

// File: tb/tb_pcs_rx_link_ctrl.sv
// Directed bench for pcs_rx_link_ctrl: 4 lanes, RST_CYC=8 and all
// stage timeouts set to 16.
module tb_pcs_rx_link_ctrl;

  localparam int LANE_N = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [LANE_N-1:0] serdes_lock_v_i = '0;
  logic [LANE_N-1:0] bs_lock_v_i = '0;
  logic [LANE_N-1:0] am_lock_v_i = '0;
  logic              deskew_lock_v_i = 1'b0;
  logic              dp_reset_o;
  logic              link_up_o;
  logic [2:0]        state_o;
  logic [7:0]        retry_cnt_o;
  logic [LANE_N-1:0] lane_fault_o;

  int n_checks = 0;
  int n_fail   = 0;
  logic [2:0] exp_q[$];

  pcs_rx_link_ctrl #(
    .IS_10G(0), .LANE_N(LANE_N), .RST_CYC(8), .BS_TIMEOUT(16),
    .AM_TIMEOUT(16), .DESKEW_TIMEOUT(16), .LOSS_FILTER(16)
  ) dut (
    .clk(clk), .reset(reset),
    .serdes_lock_v_i(serdes_lock_v_i), .bs_lock_v_i(bs_lock_v_i),
    .am_lock_v_i(am_lock_v_i), .deskew_lock_v_i(deskew_lock_v_i),
    .dp_reset_o(dp_reset_o), .link_up_o(link_up_o), .state_o(state_o),
    .retry_cnt_o(retry_cnt_o), .lane_fault_o(lane_fault_o)
  );

  // Clock
  always #5 clk = ~clk;

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_locks(input logic [3:0] s, input logic [3:0] b,
                           input logic [3:0] a, input logic d);
    serdes_lock_v_i = s;
    bs_lock_v_i     = b;
    am_lock_v_i     = a;
    deskew_lock_v_i = d;
  endtask

  // Leaves the bench just after an edge that sampled reset high (edge 0).
  task automatic apply_reset();
    reset = 1'b1;
    step(2);
    reset = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_state"}, 32'(state_o), 32'd0);
    check({tag, "_dp"},    32'(dp_reset_o), 32'd1);
    check({tag, "_link"},  32'(link_up_o), 32'd0);
    check({tag, "_retry"}, 32'(retry_cnt_o), 32'd0);
    check({tag, "_fault"}, 32'(lane_fault_o), 32'd0);
  endtask

  initial begin
    // 1: all locks high. Minimum bring-up with link up at edge 12.
    set_locks(4'hF, 4'hF, 4'hF, 1'b1);
    apply_reset();
    check_reset_values("rst0");
    for (int k = 1; k <= 12; k++) exp_q.push_back(3'((k < 8) ? 0 : k - 7));
    for (int k = 1; k <= 12; k++) begin
      step(1);
      check("bringup_state", 32'(state_o), 32'(exp_q.pop_front()));
      check("bringup_dp",    32'(dp_reset_o), (k < 8) ? 32'd1 : 32'd0);
      check("bringup_link",  32'(link_up_o), (k == 12) ? 32'd1 : 32'd0);
    end
    check("bringup_retry", 32'(retry_cnt_o), 32'd0);

    // 2: am_lock_v_i[2] low for 3 cycles while in LINK_UP.
`ifdef PCS_RX_LINK_CTRL_LOSS_FILTER_EN
    am_lock_v_i = 4'b1011;
    step(3);
    check("filt_state", 32'(state_o), 32'd5);
    check("filt_link",  32'(link_up_o), 32'd1);
    am_lock_v_i = 4'hF;
    step(1);
    check("filt_retry", 32'(retry_cnt_o), 32'd0);
`else
    am_lock_v_i = 4'b1011;
    step(1);
    check("loss_state", 32'(state_o), 32'd0);
    check("loss_dp",    32'(dp_reset_o), 32'd1);
    check("loss_link",  32'(link_up_o), 32'd0);
    check("loss_retry", 32'(retry_cnt_o), 32'd1);
    check("loss_fault", 32'(lane_fault_o), 32'd0);
    step(2);
    am_lock_v_i = 4'hF;
    step(5);
    check("relock_dp_hold", 32'(dp_reset_o), 32'd1);
    step(1);
    check("relock_dp_rel",  32'(dp_reset_o), 32'd0);
    check("relock_serdes",  32'(state_o), 32'd1);
    step(4);
    check("relock_link",    32'(link_up_o), 32'd1);
`endif

    // 3: WAIT_BS timeout with lane 2 never locking (WAIT_BS entered at edge 9).
    set_locks(4'hF, 4'b1011, 4'h0, 1'b0);
    apply_reset();
    step(24);
    check("bs_wait_state", 32'(state_o), 32'd2);
    step(1);
    check("bs_to_state", 32'(state_o), 32'd0);
    check("bs_to_dp",    32'(dp_reset_o), 32'd1);
    check("bs_to_fault", 32'(lane_fault_o), 32'h4);
    check("bs_to_retry", 32'(retry_cnt_o), 32'd1);

    // 4: block sync completes on the timeout cycle itself (edge 50).
    step(24);
    check("bs_edge_wait", 32'(state_o), 32'd2);
    bs_lock_v_i = 4'hF;
    step(1);
    check("bs_edge_state", 32'(state_o), 32'd3);
    check("bs_edge_retry", 32'(retry_cnt_o), 32'd1);
    check("bs_edge_fault", 32'(lane_fault_o), 32'h4);
    check("bs_edge_dp",    32'(dp_reset_o), 32'd0);

    // 5: SerDes lane 0 drops during WAIT_AM.
    step(3);
    check("am_wait_state", 32'(state_o), 32'd3);
    serdes_lock_v_i = 4'b1110;
    step(1);
    check("sd_loss_state", 32'(state_o), 32'd0);
    check("sd_loss_dp",    32'(dp_reset_o), 32'd1);
    check("sd_loss_fault", 32'(lane_fault_o), 32'h4);
    check("sd_loss_retry", 32'(retry_cnt_o), 32'd2);
    serdes_lock_v_i = 4'hF;

    // 6: WAIT_DESKEW timeout (entered at edge 11, times out at edge 27).
    set_locks(4'hF, 4'hF, 4'hF, 1'b0);
    apply_reset();
    step(26);
    check("dsk_wait_state", 32'(state_o), 32'd4);
    step(1);
    check("dsk_to_state", 32'(state_o), 32'd0);
    check("dsk_to_fault", 32'(lane_fault_o), 32'hF);
    check("dsk_to_retry", 32'(retry_cnt_o), 32'd1);

    // 7: 300 AM timeouts, one every 26 cycles, saturating retry_cnt_o.
    set_locks(4'hF, 4'hF, 4'b0110, 1'b0);
    apply_reset();
    step(26);
    check("am_to_state", 32'(state_o), 32'd0);
    check("am_to_fault", 32'(lane_fault_o), 32'h9);
    check("am_to_retry", 32'(retry_cnt_o), 32'd1);
    for (int n = 2; n <= 300; n++) begin
      step(26);
      if (n == 254 || n == 255 || n == 256 || n == 300)
        check("sat_retry", 32'(retry_cnt_o), 32'((n > 255) ? 255 : n));
    end
    check("sat_state", 32'(state_o), 32'd0);

    // Reset pulse in the middle of WAIT_AM.
    step(15);
    check("mid_am_state", 32'(state_o), 32'd3);
    reset = 1'b1;
    step(1);
    check_reset_values("mid_rst");
    reset = 1'b0;
    step(7);
    check("post_rst_hold", 32'(dp_reset_o), 32'd1);
    step(1);
    check("post_rst_state", 32'(state_o), 32'd1);
    check("post_rst_dp",    32'(dp_reset_o), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
